wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin Wishbone arbiter, NUM_MASTERS masters onto one slave port.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-high reset
//   wbm_*_i / wbm_*_o    flattened master-side buses, master k at slice k
//   wbs_*_o / wbs_*_i    slave-side bus toward the downstream interconnect
//   grant_o              one-hot current owner, zero while idle
//
// A grant is registered one cycle after a request. It is held until the owner
// drops cyc. A watchdog aborts a stalled strobe after TIMEOUT cycles by
// erroring the owner for one cycle. TIMEOUT=0 disables the watchdog.
module wb_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic [NUM_MASTERS*32-1:0]  wbm_adr_i,
    input  logic [NUM_MASTERS*32-1:0]  wbm_dat_i,
    input  logic [NUM_MASTERS*4-1:0]   wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]     wbm_we_i,
    input  logic [NUM_MASTERS-1:0]     wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]     wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]   wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]   wbm_bte_i,
    output logic [NUM_MASTERS*32-1:0]  wbm_dat_o,
    output logic [NUM_MASTERS-1:0]     wbm_ack_o,
    output logic [NUM_MASTERS-1:0]     wbm_err_o,
    output logic [NUM_MASTERS-1:0]     wbm_rty_o,
    output logic [31:0]                wbs_adr_o,
    output logic [31:0]                wbs_dat_o,
    output logic [3:0]                 wbs_sel_o,
    output logic                       wbs_we_o,
    output logic                       wbs_cyc_o,
    output logic                       wbs_stb_o,
    output logic [2:0]                 wbs_cti_o,
    output logic [1:0]                 wbs_bte_o,
    input  logic [31:0]                wbs_dat_i,
    input  logic                       wbs_ack_i,
    input  logic                       wbs_err_i,
    input  logic                       wbs_rty_i,
    output logic [NUM_MASTERS-1:0]     grant_o
);

    localparam int IW  = $clog2(NUM_MASTERS);
    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic [IW:0]    NM      = (IW + 1)'(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, BUSY, ABORT} state_t;

    state_t                 state_q;
    logic [IW-1:0]          idx_q;
    logic [IW-1:0]          last_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [WDW-1:0]         wd_q;

    logic [IW-1:0] win;
    logic [IW:0]   cand;
    logic          found;

    // Round-robin search starting just after the last owner.
    always_comb begin
        win   = last_q;
        cand  = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            cand = {1'b0, last_q} + (IW + 1)'(i);
            if (cand >= NM) cand = cand - NM;
            if (!found && wbm_cyc_i[cand[IW-1:0]]) begin
                win   = cand[IW-1:0];
                found = 1'b1;
            end
        end
    end

    logic cyc_g, stb_g, term, busy_on, route, stalled;

    assign cyc_g   = wbm_cyc_i[idx_q];
    assign stb_g   = wbm_stb_i[idx_q];
    assign term    = wbs_ack_i | wbs_err_i | wbs_rty_i;
    // Reset gates the bus directly so it drops in the same cycle it rises.
    assign busy_on = (state_q == BUSY) && cyc_g && !wb_rst_i;
    assign route   = (state_q != IDLE) && !wb_rst_i;
    // A termination in the same cycle as the last stall clears the watchdog.
    assign stalled = busy_on && stb_g && !term;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            last_q  <= IW'(NUM_MASTERS - 1);
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    wd_q <= '0;
                    if (|wbm_cyc_i) begin
                        idx_q   <= win;
                        grant_q <= NUM_MASTERS'(1) << win;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (!cyc_g) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        last_q  <= idx_q;
                        wd_q    <= '0;
                    end else if (stalled && (TIMEOUT > 0)) begin
                        // Counter reads TIMEOUT during the abort cycle itself.
                        wd_q <= wd_q + 1'b1;
                        if (wd_q == WD_LAST) state_q <= ABORT;
                    end else begin
                        wd_q <= '0;
                    end
                end
                ABORT: begin
                    wd_q <= '0;
                    if (cyc_g) begin
                        state_q <= BUSY;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                        last_q  <= idx_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};

    always_comb begin
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        wbs_sel_o = '0;
        wbs_we_o  = 1'b0;
        wbs_cti_o = '0;
        wbs_bte_o = '0;
        if (route) begin
            wbs_adr_o = wbm_adr_i[int'(idx_q)*32 +: 32];
            wbs_dat_o = wbm_dat_i[int'(idx_q)*32 +: 32];
            wbs_sel_o = wbm_sel_i[int'(idx_q)*4 +: 4];
            wbs_we_o  = wbm_we_i[idx_q];
            wbs_cti_o = wbm_cti_i[int'(idx_q)*3 +: 3];
            wbs_bte_o = wbm_bte_i[int'(idx_q)*2 +: 2];
        end
        wbs_cyc_o = busy_on;
        wbs_stb_o = busy_on && stb_g;
    end

    // Terminations reach only the owner; ABORT drops slave terminations.
    always_comb begin
        wbm_ack_o = '0;
        wbm_err_o = '0;
        wbm_rty_o = '0;
        wbm_ack_o[idx_q] = busy_on && wbs_ack_i;
        wbm_rty_o[idx_q] = busy_on && wbs_rty_i;
        wbm_err_o[idx_q] = (busy_on && wbs_err_i) || ((state_q == ABORT) && !wb_rst_i);
    end

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
    localparam int N  = 2;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N*32-1:0] adr_i, dat_i, dat_o;
    logic [N*4-1:0]  sel_i;
    logic [N-1:0]    we_i, cyc_i, stb_i, ack_o, err_o, rty_o, grant;
    logic [N*3-1:0]  cti_i;
    logic [N*2-1:0]  bte_i;
    logic [31:0]     s_adr, s_dat, s_dat_i;
    logic [3:0]      s_sel;
    logic            s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
    logic [2:0]      s_cti;
    logic [1:0]      s_bte;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    wb_arbiter #(.NUM_MASTERS(N), .TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbm_adr_i(adr_i), .wbm_dat_i(dat_i), .wbm_sel_i(sel_i), .wbm_we_i(we_i),
        .wbm_cyc_i(cyc_i), .wbm_stb_i(stb_i), .wbm_cti_i(cti_i), .wbm_bte_i(bte_i),
        .wbm_dat_o(dat_o), .wbm_ack_o(ack_o), .wbm_err_o(err_o), .wbm_rty_o(rty_o),
        .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
        .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
        .wbs_dat_i(s_dat_i), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
        .grant_o(grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        adr_i = '0; dat_i = '0; sel_i = '0; we_i = '0; cyc_i = '0; stb_i = '0;
        cti_i = '0; bte_i = '0; s_dat_i = '0; s_ack = 0; s_err = 0; s_rty = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        adr_i = {32'h1111_2222, 32'h3333_4444}; dat_i = {32'h5555_6666, 32'h7777_8888};
        sel_i = 8'hff; we_i = 2'b11; cyc_i = 2'b11; stb_i = 2'b11;
        s_ack = 1; s_err = 1; s_rty = 1;
        tick();
        @(negedge clk);
        checks++;
        if ({grant, s_cyc, s_stb, s_we, ack_o, err_o, rty_o} !== '0 ||
            s_adr !== 32'h0 || s_dat !== 32'h0 || s_sel !== 4'h0) begin
            failures++;
            $display("FAIL reset: grant=%b cyc=%b stb=%b we=%b ack=%b err=%b rty=%b adr=%h dat=%h sel=%h, want all 0",
                     grant, s_cyc, s_stb, s_we, ack_o, err_o, rty_o, s_adr, s_dat, s_sel);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        cyc_i = 2'b10; stb_i = 2'b10; adr_i[63:32] = 32'h2000_0004;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL single_latency: grant=%b want 00", grant); end
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_adr !== 32'h2000_0004 || s_cyc !== 1'b1 || ack_o !== 2'b00) begin
            failures++;
            $display("FAIL single_grant: grant=%b adr=%h cyc=%b ack=%b want 10 20000004 1 00", grant, s_adr, s_cyc, ack_o);
        end
        tick();
        tick();
        s_ack = 1;
        @(negedge clk);
        checks++;
        if (ack_o !== 2'b10) begin failures++; $display("FAIL single_ack: ack=%b want 10", ack_o); end
        tick();
        s_ack = 0; cyc_i = 0; stb_i = 0;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0 || grant !== 2'b10) begin
            failures++; $display("FAIL single_drop: cyc=%b grant=%b want 0 10", s_cyc, grant);
        end
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b00) begin failures++; $display("FAIL single_idle: grant=%b want 00", grant); end
    endtask

    task automatic test_round_robin();
        do_reset();
        adr_i = {32'hB000_0001, 32'hA000_0000};
        cyc_i = 2'b11; stb_i = 2'b11;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01 || s_adr !== 32'hA000_0000) begin
            failures++; $display("FAIL rr_first: grant=%b adr=%h want 01 a0000000", grant, s_adr);
        end
        tick();
        cyc_i = 2'b10; stb_i = 2'b10;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            failures++; $display("FAIL rr_release: cyc=%b stb=%b want 0 0", s_cyc, s_stb);
        end
        tick();
        cyc_i = 2'b11; stb_i = 2'b11;
        @(negedge clk);
        checks++;
        if (grant !== 2'b00 || s_cyc !== 1'b0) begin
            failures++; $display("FAIL rr_gap: grant=%b cyc=%b want 00 0", grant, s_cyc);
        end
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10 || s_adr !== 32'hB000_0001) begin
            failures++; $display("FAIL rr_second: grant=%b adr=%h want 10 b0000001", grant, s_adr);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_burst();
        logic [2:0] want_cti;
        do_reset();
        cyc_i = 2'b11; stb_i = 2'b11;
        tick();
        for (int b = 0; b < 4; b++) begin
            want_cti = (b == 3) ? 3'b111 : 3'b010;
            cti_i[2:0] = want_cti;
            s_ack = 1;
            @(negedge clk);
            checks++;
            if (grant !== 2'b01 || ack_o !== 2'b01 || s_cti !== want_cti) begin
                failures++;
                $display("FAIL burst_beat%0d: grant=%b ack=%b cti=%b want 01 01 %b", b, grant, ack_o, s_cti, want_cti);
            end
            tick();
        end
        s_ack = 0; cyc_i = 2'b10; stb_i = 2'b10;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b10) begin failures++; $display("FAIL burst_handoff: grant=%b want 10", grant); end
        clear_inputs();
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        cyc_i = 2'b01; stb_i = 2'b01;
        tick();
        for (int i = 0; i < TO; i++) begin
            @(negedge clk);
            checks++;
            if (s_cyc !== 1'b1 || err_o !== 2'b00) begin
                failures++; $display("FAIL timeout_stall%0d: cyc=%b err=%b want 1 00", i, s_cyc, err_o);
            end
            tick();
        end
        s_ack = 1;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b0 || s_stb !== 1'b0 || err_o !== 2'b01 || ack_o !== 2'b00 || grant !== 2'b01) begin
            failures++;
            $display("FAIL timeout_abort: cyc=%b stb=%b err=%b ack=%b grant=%b want 0 0 01 00 01",
                     s_cyc, s_stb, err_o, ack_o, grant);
        end
        tick();
        s_ack = 0;
        @(negedge clk);
        checks++;
        if (s_cyc !== 1'b1 || err_o !== 2'b00) begin
            failures++; $display("FAIL timeout_resume: cyc=%b err=%b want 1 00", s_cyc, err_o);
        end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc_i = 2'b10; stb_i = 2'b10;
        tick();
        tick();
        s_ack = 1;
        #2 rst = 1'b1;
        #1;
        checks++;
        if (s_cyc !== 1'b0 || ack_o !== 2'b00 || grant !== 2'b00) begin
            failures++; $display("FAIL reset_mid: cyc=%b ack=%b grant=%b want 0 00 00", s_cyc, ack_o, grant);
        end
        tick();
        rst = 1'b0; s_ack = 0; cyc_i = 2'b11; stb_i = 2'b11;
        tick();
        @(negedge clk);
        checks++;
        if (grant !== 2'b01) begin failures++; $display("FAIL reset_mid_regrant: grant=%b want 01", grant); end
        clear_inputs();
        tick();
    endtask

    // Reference: owner (-1 = none), last owner, stall count, abort flag.
    task automatic test_random();
        int owner, last, cnt, pct;
        bit abort_c;
        logic [N-1:0] e_grant, e_ack, e_err, e_rty;
        logic e_cyc, e_stb;
        logic [31:0] e_adr;
        do_reset();
        owner = -1; last = N - 1; cnt = 0; abort_c = 0;
        for (int c = 0; c < 600; c++) begin
            pct = (c < 300) ? 35 : 8;
            for (int k = 0; k < N; k++) begin
                if (cyc_i[k]) cyc_i[k] = ($urandom_range(99) >= 15);
                else          cyc_i[k] = ($urandom_range(99) < 30);
                stb_i[k] = cyc_i[k] && ($urandom_range(99) < 80);
            end
            adr_i = {$urandom, $urandom}; dat_i = {$urandom, $urandom};
            s_dat_i = $urandom;
            s_ack = ($urandom_range(99) < pct);
            s_err = ($urandom_range(99) < 4);
            s_rty = ($urandom_range(99) < 4);
            @(negedge clk);
            e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0; e_cyc = 0; e_stb = 0; e_adr = '0;
            if (owner >= 0) begin
                e_grant[owner] = 1'b1;
                if (abort_c) e_err[owner] = 1'b1;
                else if (cyc_i[owner]) begin
                    e_cyc = 1; e_stb = stb_i[owner]; e_adr = adr_i[owner*32 +: 32];
                    e_ack[owner] = s_ack; e_err[owner] = s_err; e_rty[owner] = s_rty;
                end
            end
            checks++;
            if (grant !== e_grant || s_cyc !== e_cyc || s_stb !== e_stb || ack_o !== e_ack ||
                err_o !== e_err || rty_o !== e_rty || (e_cyc && s_adr !== e_adr) ||
                dat_o !== {N{s_dat_i}}) begin
                failures++;
                $display("FAIL random_c%0d: grant=%b cyc=%b stb=%b ack=%b err=%b rty=%b adr=%h want %b %b %b %b %b %b %h",
                         c, grant, s_cyc, s_stb, ack_o, err_o, rty_o, s_adr,
                         e_grant, e_cyc, e_stb, e_ack, e_err, e_rty, e_adr);
            end
            if (owner < 0) begin
                for (int i = 1; i <= N && owner < 0; i++)
                    if (cyc_i[(last + i) % N]) owner = (last + i) % N;
            end else if (abort_c) begin
                abort_c = 0; cnt = 0;
                if (!cyc_i[owner]) begin last = owner; owner = -1; end
            end else if (!cyc_i[owner]) begin
                last = owner; owner = -1; cnt = 0;
            end else if (stb_i[owner] && !(s_ack || s_err || s_rty)) begin
                cnt++;
                if (cnt == TO) begin abort_c = 1; cnt = 0; end
            end else cnt = 0;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_burst();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
